// File: rtl/reg_bank_ctl.sv
// reg_bank_ctl: bank of NREG registers of WIDTH bits between the common bus and
// the ALU. One register per cycle (picked by WSEL) can be cleared, loaded,
// incremented or decremented. CLRALL clears the whole bank. DR is a registered,
// write-through read port, and CO/ZR/SATF are status flags for the sequencer.
module reg_bank_ctl #(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 4,
  parameter  bit SAT   = 1'b0,
  parameter  int STEP  = 1,
  localparam int SELW  = $clog2(NREG)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] inDR,
  input  logic [SELW-1:0]  WSEL,
  input  logic             LD,
  input  logic             INR,
  input  logic             DEC,
  input  logic             CLR,
  input  logic             CLRALL,
  input  logic [SELW-1:0]  RSEL,
  output logic [WIDTH-1:0] DR,
  output logic             CO,
  output logic             ZR,
  output logic             SATF
);

  localparam logic [WIDTH:0] stepExt = (WIDTH+1)'(STEP);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLRALL,
    OP_CLR,
    OP_LD,
    OP_INR,
    OP_DEC
  } opKind_t;

  logic [WIDTH-1:0] regs [NREG];
  logic             satfQ;

  opKind_t          op;
  logic [WIDTH-1:0] curVal;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] nextVal;
  logic [WIDTH-1:0] nextDr;
  logic             wrEn;
  logic             nextCo;
  logic             nextSatf;

  assign curVal = regs[WSEL];
  assign sum    = {1'b0, curVal} + stepExt;
  // The top bit of the extended difference is the borrow (curVal < STEP).
  assign diff   = {1'b0, curVal} - stepExt;

  // Resolve the single operation for this cycle: CLRALL > CLR > LD > INR/DEC.
  always_comb begin
    if (CLRALL)           op = OP_CLRALL;
    else if (CLR)         op = OP_CLR;
    else if (LD)          op = OP_LD;
    else if (INR && !DEC) op = OP_INR;
    else if (DEC && !INR) op = OP_DEC;
    else                  op = OP_NONE;
  end

  // Next value of the selected register and next carry/saturation flags.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
    wrEn     = 1'b0;
    nextVal  = curVal;
    nextCo   = CO;
    nextSatf = satfQ;
    case (op)
      OP_CLRALL: begin
        nextCo   = 1'b0;
        nextSatf = 1'b0;
      end
      OP_CLR: begin
        wrEn     = 1'b1;
        nextVal  = '0;
        nextCo   = 1'b0;
        nextSatf = 1'b0;
      end
      OP_LD: begin
        wrEn    = 1'b1;
        nextVal = inDR;
      end
      OP_INR: begin
        wrEn = 1'b1;
        if (SAT && sum[WIDTH]) begin
          nextVal  = '1;
          nextCo   = 1'b1;
          nextSatf = 1'b1;
        end else begin
          nextVal  = sum[WIDTH-1:0];
          nextCo   = sum[WIDTH];
          nextSatf = 1'b0;
        end
      end
      OP_DEC: begin
        wrEn   = 1'b1;
        nextCo = diff[WIDTH];
        if (SAT && diff[WIDTH]) begin
          nextVal  = '0;
          nextSatf = 1'b1;
        end else begin
          nextVal  = diff[WIDTH-1:0];
          nextSatf = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Read port sees the post-update value, so a same-cycle write shows through.
  always_comb begin
    if (op == OP_CLRALL)           nextDr = '0;
    else if (wrEn && RSEL == WSEL) nextDr = nextVal;
    else                           nextDr = regs[RSEL];
  end

  // Bank, read register and flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the bank is small and must read back as zero after reset, so every entry is reset rather than left uninitialised like a RAM.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      DR    <= '0;
      CO    <= 1'b0;
      satfQ <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample pre-edge values, independent of statement order.
      for (int i = 0; i < NREG; i++) begin
        if (op == OP_CLRALL)                 regs[i] <= '0;
        else if (wrEn && WSEL == SELW'(i))   regs[i] <= nextVal;
      end
      DR    <= nextDr;
      CO    <= nextCo;
      satfQ <= nextSatf;
    end
  end

  assign ZR   = (DR == '0);
  assign SATF = SAT ? satfQ : 1'b0;

endmodule

// File: doc/reg_bank_ctl.md
Name: reg_bank_ctl

Overview:
- Parametrised successor to the single 16-bit data register with load/increment/clear.
- Holds NREG registers of WIDTH bits. Each cycle, one register, selected by a write index, can be loaded, incremented, decremented or cleared. A single synchronous broadcast clear covers the whole bank.
- Sits between the common bus and the ALU of the basic-computer datapath: it supplies a registered read port (DR) and carry and zero status flags to the control sequencer.

Parameters:
- WIDTH, 16, bit width of each register and of the bus.
- NREG, 4, number of registers (power of 2, ≥2).
- SAT, 0: 0 means INR/DEC wrap modulo 2^WIDTH; 1 means they saturate at all-ones or zero.
- STEP, 1, increment/decrement amount (1 ≤ STEP < 2^WIDTH).

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- inDR  in  WIDTH  load data from the common bus.
- WSEL  in  log2(NREG)  target register for LD/INR/DEC/CLR.
- LD  in  1  load inDR into R[WSEL].
- INR  in  1  increment R[WSEL] by STEP.
- DEC  in  1  decrement R[WSEL] by STEP.
- CLR  in  1  synchronous clear of R[WSEL].
- CLRALL  in  1  synchronous clear of all registers.
- RSEL  in  log2(NREG)  read select.
- DR  out  WIDTH  registered copy of R[RSEL].
- CO  out  1  carry/borrow from the last INR/DEC (sticky until the next INR/DEC, CLR or CLRALL).
- ZR  out  1  DR == 0.
- SATF  out  1  the last INR/DEC was clamped (SAT=1 only; tied 0 when SAT=0).

Behaviour:
- RST_N low (async):
  - all R[i] = 0, DR = 0, CO = 0, SATF = 0, ZR = 1.
  - This holds mid-operation too: any op in flight is discarded.
- Per rising edge, a single op applies to R[WSEL], chosen by priority CLRALL > CLR > LD > INR/DEC.
  - INR and DEC both high: no-op on the register; CO and SATF unchanged.
  - Unselected registers always hold.
- CLRALL: every R[i] = 0, CO = 0, SATF = 0.
- CLR: R[WSEL] = 0, CO = 0, SATF = 0.
- LD: R[WSEL] = inDR; CO and SATF unchanged.
- INR: compute sum = R + STEP at WIDTH+1 bits.
  - SAT=0: R = sum[WIDTH-1:0]; CO = sum[WIDTH]; SATF = 0.
  - SAT=1 and sum[WIDTH] = 1: R = all-ones; CO = 1; SATF = 1.
  - SAT=1 and sum[WIDTH] = 0: R = sum; CO = 0; SATF = 0.
- DEC: compute diff = R − STEP.
  - Borrow (R < STEP) sets CO = 1.
  - SAT=0: R wraps.
  - SAT=1 with borrow: R = 0 and SATF = 1.
  - No borrow: CO = 0, SATF = 0.
- Read path: DR is updated every edge to the post-update value of R[RSEL].
  - This gives write-through: if RSEL == WSEL in the same cycle, DR shows the new value. Read latency is 1 cycle.
  - ZR is combinational from DR.
- No ops asserted: all state holds.
- X-free: an out-of-range WSEL cannot occur because NREG is a power of 2.

Test Plan:
1. Reset, then LD with WSEL=1, inDR=16'h1234, RSEL=1 → DR=16'h1234 one cycle later; ZR=0. Register 0 reads 0 (ZR=1).
2. SAT=0, STEP=1: LD R2=16'hFFFF, then INR on R2 → R2=16'h0000, CO=1, ZR=1. Next, DEC on R2 → R2=16'hFFFF, CO=1. Then INR/DEC on a value of 5 → CO=0.
3. SAT=1, STEP=4: LD R0=16'hFFFE, then INR → R0=16'hFFFF, CO=1, SATF=1. Then LD R0=3 and DEC → R0=0, SATF=1.
4. Priority, in one cycle:
   - CLR+LD+INR on R3 holding 16'h00AA → R3=0.
   - LD+INR with inDR=16'h0010 → R3=16'h0010.
   - INR+DEC → R3 unchanged.
   - CLRALL with WSEL=2 and LD → all registers 0.
5. Write-through: RSEL=WSEL=1, INR on R1=7 → DR=8 on the same edge. RSEL=0 while R1 changes → DR holds R0.
6. Async reset: assert RST_N low between edges while R1=16'h5555 with INR pending → DR=0, CO=0 and ZR=1 immediately. After release, all R read 0.
